shift_seq: RTL and testbench
============================

SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 The block SHALL have parameter BIG_STEP, default 4, giving the coarse shift distance per step; legal values are 2, 4 and 8.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit, a request strobe that is sampled only in IDLE.
REQ-005 The block SHALL have port a, input, 32 bits, the operand captured at start.
REQ-006 The block SHALL have port shamt, input, 5 bits, the shift amount (0..31) captured at start.
REQ-007 The block SHALL have port mode, input, 2 bits, captured at start: 00 = logical right, 01 = logical left, 10 = arithmetic right, 11 = invalid.
REQ-008 The block SHALL have port b, output, 32 bits, the result register.
REQ-009 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-010 The block SHALL have port done, output, 1 bit, a one-cycle completion pulse.

Function
REQ-011 The block SHALL implement the states IDLE, SHIFT and DONE; an edge in IDLE with start=1 is the accept edge k.
REQ-012 At edge k: load b=a, rem=shamt, mode register; go to DONE if shamt=0 or mode=11, else go to SHIFT.
REQ-013 For mode=11 at edge k: load b=0 instead of a.
REQ-014 Each SHIFT edge performs exactly one step on b: if rem>=BIG_STEP, shift by BIG_STEP and subtract BIG_STEP from rem; otherwise shift by 1 and subtract 1.
REQ-015 Step semantics SHALL be: 00 zero-fill from the MSB side; 01 zero-fill from the LSB side; 10 fill vacated MSBs with the current b[31].
REQ-016 The state SHALL go SHIFT->DONE on the edge where rem after the step is 0.
REQ-017 Step count SHALL be n = shamt/BIG_STEP + shamt%BIG_STEP; with BIG_STEP=4, shamt=31 gives n=10 (the maximum).
REQ-018 done SHALL be high for exactly the one cycle following edge k+n (for n=0, the cycle after edge k); DONE->IDLE unconditionally.
REQ-019 b SHALL hold the final result from done until the next accept edge; intermediate values are visible during SHIFT and are not valid.
REQ-020 start while busy=1 (including the DONE cycle) SHALL be ignored; it is not queued.
REQ-021 Changes on a, shamt or mode after edge k SHALL NOT affect the operation in flight.
REQ-022 The final b SHALL equal a>>shamt, a<<shamt or the sign-extended a>>shamt (per mode), for all shamt 0..31.

Reset
REQ-023 While rst=1, regardless of clk: state=IDLE, b=0, rem=0, busy=0, done=0.
REQ-024 Reset asserted mid-SHIFT or in DONE SHALL abort the operation with no done pulse.
REQ-025 After reset deasserts, the first start edge SHALL be accepted.

Structure
REQ-026 A shared package SHALL hold the mode encodings (SRL=00, SLL=01, SRA=10, invalid=11), the state enumeration, and the constant 32 for data width.
REQ-027 The single-step datapath SHALL be a combinational sub-module shift_step (parameter SI; inputs a, mode; output b), instantiated twice (SI=BIG_STEP and SI=1) with a mux selecting by rem.
REQ-028 The FSM, rem counter and b register SHALL live in shift_seq; target 120-250 lines total.

Verification
REQ-029 SRL: a=0xF000_0000, shamt=4, mode=00 -> 1 step, done in the cycle after edge k+1, b=0x0F00_0000.
REQ-030 SRA: a=0x8000_0000, shamt=31, mode=10 -> 10 steps, done after edge k+10, b=0xFFFF_FFFF.
REQ-031 SLL: a=0x0000_0001, shamt=5, mode=01 -> 2 steps (4 then 1), b=0x0000_0020; a start pulse during SHIFT is ignored and produces no second done.
REQ-032 shamt=0, a=0x1234_5678, mode=00 -> done in the cycle after edge k, b=0x1234_5678; mode=11 with any a -> done after edge k, b=0.
REQ-033 rst asserted asynchronously mid-SHIFT (a=0xDEAD_BEEF, shamt=31) -> b=0, busy=0 immediately, and done never pulses.
REQ-034 Random sweep of all modes and shamt 0..31 against the REQ-022 model -> b is correct at every done, and done cycle = k+n+1.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types for the multi-cycle shifter.
// Mode encodings, FSM states and data width.
package shift_seq_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        MODE_SRL = 2'b00,
        MODE_SLL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_INV = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of fixed distance SI.
// Invalid mode passes the operand through unchanged.
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int SI = 1
) (
    input  logic [DATA_W-1:0] a,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] b
);

    // select the shift flavour for this step
    always_comb begin
        b = a;
        unique case (mode)
            MODE_SRL: b = a >> SI;
            MODE_SLL: b = a << SI;
            MODE_SRA: b = $signed(a) >>> SI;
            default:  b = a;
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle barrel-free shifter: coarse steps of
// BIG_STEP, then single-bit steps, one per clock.
module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int BIG_STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [4:0]        shamt,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done
);

    localparam logic [4:0] BIG = 5'(BIG_STEP);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [4:0]        rem_q, rem_d;
    mode_e             mode_q, mode_d;

    logic [DATA_W-1:0] big_b;
    logic [DATA_W-1:0] one_b;
    logic              use_big;

    shift_step #(.SI(BIG_STEP)) u_big (
        .a    (b_q),
        .mode (mode_q),
        .b    (big_b)
    );

    shift_step #(.SI(1)) u_one (
        .a    (b_q),
        .mode (mode_q),
        .b    (one_b)
    );

    assign use_big = (rem_q >= BIG);

    // next-state, operand capture and per-step update
    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d = mode_e'(mode);
                    rem_d  = shamt;
                    b_d    = (mode == MODE_INV) ? '0 : a;
                    if (shamt == 5'd0 || mode == MODE_INV)
                        state_d = S_DONE;
                    else
                        state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                b_d   = use_big ? big_b : one_b;
                rem_d = rem_q - (use_big ? BIG : 5'd1);
                if (rem_d == 5'd0)
                    state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // state, result and remaining-count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            b_q     <= '0;
            rem_q   <= '0;
            mode_q  <= MODE_SRL;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
        end
    end

    assign b    = b_q;
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq with BIG_STEP=4.
// Expected results come from hand values and a plain shift model.
module tb_shift_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [1:0]  mode;
    logic [31:0] b;
    logic        busy;
    logic        done;

    int total;
    int bad;

    shift_seq #(.BIG_STEP(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .shamt (shamt),
        .mode  (mode),
        .b     (b),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_b(input logic [31:0] x,
                                            input int sh,
                                            input logic [1:0] m);
        logic [31:0] r;
        case (m)
            2'b00: r = x >> sh;
            2'b01: r = x << sh;
            2'b10: r = $signed(x) >>> sh;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    function automatic int model_n(input int sh, input logic [1:0] m);
        if (m == 2'b11) return 0;
        return sh / 4 + sh % 4;
    endfunction

    // Launch one operation and follow it to done.
    // poke=1 pulses start (with other operands) in the first busy cycle.
    task automatic run_op(input string tag,
                          input logic [31:0] xa,
                          input int sh,
                          input logic [1:0] m,
                          input logic [31:0] exp_b,
                          input int exp_n,
                          input bit poke);
        int i;
        start = 1'b1;
        a     = xa;
        shamt = 5'(sh);
        mode  = m;
        @(posedge clk); #1;
        start = poke;
        a     = 32'hA5A5_5A5A;
        shamt = 5'd3;
        mode  = 2'b01;
        i = 0;
        if (exp_n > 0)
            chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
        while (done !== 1'b1 && i < 40) begin
            @(posedge clk); #1;
            start = 1'b0;
            i++;
        end
        start = 1'b0;
        chk({tag, ".timeout"}, {31'd0, (i < 40)}, 32'd1);
        chk({tag, ".steps"}, 32'(i), 32'(exp_n));
        chk({tag, ".b"}, b, exp_b);
        @(posedge clk); #1;
        chk({tag, ".done1cyc"}, {31'd0, done}, 32'd0);
        chk({tag, ".idle"}, {31'd0, busy}, 32'd0);
        chk({tag, ".hold"}, b, exp_b);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = 32'h0;
        shamt = 5'd0;
        mode  = 2'b00;

        #12;
        chk("rst.b", b, 32'h0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("srl4", 32'hF000_0000, 4, 2'b00, 32'h0F00_0000, 1, 1'b0);
        run_op("sra31", 32'h8000_0000, 31, 2'b10, 32'hFFFF_FFFF, 10, 1'b0);
        run_op("sll5", 32'h0000_0001, 5, 2'b01, 32'h0000_0020, 2, 1'b1);
        run_op("zero", 32'h1234_5678, 0, 2'b00, 32'h1234_5678, 0, 1'b0);
        run_op("inv", 32'hCAFE_F00D, 17, 2'b11, 32'h0000_0000, 0, 1'b0);
        run_op("sra_pos", 32'h7000_0000, 6, 2'b10, 32'h01C0_0000, 3, 1'b0);
        run_op("sra_neg", 32'hF000_0000, 30, 2'b10, 32'hFFFF_FFFF, 9, 1'b0);

        // start held through the DONE cycle must not be queued
        start = 1'b1;
        a     = 32'h0000_00F0;
        shamt = 5'd4;
        mode  = 2'b00;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("dq.done", {31'd0, done}, 32'd1);
        chk("dq.b", b, 32'h0000_000F);
        start = 1'b1;
        a     = 32'hFFFF_FFFF;
        shamt = 5'd8;
        @(posedge clk); #1;
        start = 1'b0;
        chk("dq.idle", {31'd0, busy}, 32'd0);
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            chk("dq.nodone", {31'd0, done}, 32'd0);
        end
        chk("dq.hold", b, 32'h0000_000F);

        // asynchronous reset in the middle of a long shift
        start = 1'b1;
        a     = 32'hDEAD_BEEF;
        shamt = 5'd31;
        mode  = 2'b00;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("ar.busy_pre", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar.b", b, 32'h0);
        chk("ar.busy", {31'd0, busy}, 32'd0);
        chk("ar.done", {31'd0, done}, 32'd0);
        @(posedge clk); #3;
        rst = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(posedge clk); #1;
            chk("ar.nodone", {31'd0, done}, 32'd0);
        end
        run_op("post_rst", 32'h0000_FF00, 8, 2'b00, 32'h0000_00FF, 2, 1'b0);

        // all modes and every shift amount against the plain model
        for (int m = 0; m < 4; m++) begin
            for (int s = 0; s < 32; s++) begin
                logic [31:0] x;
                x = $urandom;
                if (s % 3 == 0) x[31] = 1'b1;
                run_op("sweep", x, s, 2'(m),
                       model_b(x, s, 2'(m)),
                       model_n(s, 2'(m)), 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
